arm_control_fsm: RTL
====================

# arm_control_fsm

Microcoded-style control unit for the ARM-subset datapath. It sequences fetch, decode and execute for data-processing, LDR/STR and B/BL instructions, and drives the select inputs of the datapath multiplexers (MA, MB, MC, MD, MJ). It also drives the ALU opcode, the register and latch load enables, and the memory handshake. It is the producer side of the datapath mux-select interface and sits between the instruction register, condition tester, memory and datapath.

## Interface
Parameters: none.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces state S0 and all outputs to 0 immediately
- ir  in  32  current instruction register contents
- cond_true  in  1  condition tester result for ir[31:28] against current flags
- moc  in  1  memory operation complete
- MA  out  2  port A address select: 0 Rn ir[19:16], 1 Rd field, 2 R15
- MB  out  2  ALU B source: 0 reg port B, 1 shifter out, 2 MDR, 3 constant (unused, never driven)
- MC  out  3  write address: 0 Rd, 1 Rn, 2 R14, 3 R15
- MD  out  1  ALU op source: 0 ir[24:21], 1 OP
- ME  out  1  MDR source: 0 ALU out, 1 memory data
- MJ  out  2  port B address: 0 ir[3:0], 2 ir[15:12]
- OP  out  5  ALU op when MD=1: 2 SUB, 4 ADD, 13 MOVB (pass B), 16 PASSA, 17 A+4
- rf_ld, ir_ld, mar_ld, mdr_ld, flags_ld  out  1 each  load enables
- mem_mov  out  1  memory request; mem_rw  out  1  1 read, 0 write
- state  out  4  current state, debug

## Operation
- Outputs are decoded combinationally from state, with ir and moc as qualifiers. Any output not listed for a state is 0.
- S0 RESET: all 0. Next state S1.
- S1 FETCH1: MA=2, MD=1, OP=16, mar_ld=1. Next state S2.
- S2 FETCH2: MA=2, MD=1, OP=17, MC=3, rf_ld=1, mem_mov=1, mem_rw=1. Next state S3.
- S3 FETCH3: mem_mov=1, mem_rw=1, ir_ld=moc. Holds in S3 while moc=0. Goes to S4 when moc=1.
- S4 DECODE: no loads. Transitions, in order:
  - cond_true=0 → S1
  - ir[27:26]=00 → S5
  - ir[27:25]=010 with ir[20]=1 → S6; with ir[20]=0 → S9
  - ir[27:25]=101 → S12 if ir[24]=1, else S13
  - any other encoding → S1 (NOP)
- S5 DP: MA=0, MB=1, MD=0, MC=0, rf_ld=(ir[24:23]!=2'b10), flags_ld=ir[20]. Next state S1.
- S6 / S9 address: MA=0, MB=1, MD=1, OP=(ir[23]?4:2), mar_ld=1. S6 goes to S7; S9 goes to S10.
- S7 LDR read: mem_mov=1, mem_rw=1, ME=1, mdr_ld=1. Holds in S7 until moc=1, then goes to S8.
- S8 LDR writeback: MB=2, MD=1, OP=13, MC=0, rf_ld=1. Next state S1.
- S10 STR data: MJ=2, MB=0, MD=1, OP=13, ME=0, mdr_ld=1. Next state S11.
- S11 STR write: mem_mov=1, mem_rw=0. Holds in S11 until moc=1, then goes to S1.
- S12 link: MA=2, MD=1, OP=16, MC=2, rf_ld=1. Next state S13.
- S13 branch: MA=2, MB=1, MD=1, OP=4, MC=3, rf_ld=1. Next state S1.
  - Target = fetched PC + 4 + (sign-extended offset << 2); the shifter supplies the shifted offset.
- Encodings 14 and 15 are unused. If reached, the FSM behaves as S0 and goes to S1.
- No writeback, pre/post-index or byte/halfword forms are supported. ir[24], ir[22] and ir[21] are ignored for LDR/STR.

## Timing
- After reset deassertion: S0 for one cycle, then S1. Asynchronous reset drops mem_mov in the same cycle, including mid-handshake in S3, S7 or S11.
- Instruction latencies, with moc returned in the first wait cycle:
  - data-processing: 5 cycles (S1, S2, S3, S4, S5)
  - LDR: 7 cycles
  - STR: 7 cycles
  - B: 5 cycles
  - BL: 6 cycles
  - condition-failed: 4 cycles
- Each extra cycle moc stays low adds one cycle in S3, S7 or S11.
- ir_ld in S3 is Mealy: it is asserted in the same cycle moc is sampled high.
- mdr_ld in S7 stays high every wait cycle, so MDR holds the last memory data.
- moc is ignored outside S3, S7 and S11.
- The ir value used in S4 is the one loaded at the end of S3.

## Test plan
- Reset: hold reset 3 cycles, then release → state=0 and all outputs 0 during reset; next cycle state=1 with MA=2, OP=16, mar_ld=1.
- ADD, ir=32'hE0821003, cond_true=1, moc=1 in S3 → states 1,2,3,4,5,1. In S5: MA=0, MB=1, MD=0, MC=0, rf_ld=1, flags_ld=0.
- CMP, ir=32'hE1520003 → in S5: rf_ld=0, flags_ld=1.
- LDR, ir=32'hE5910004, moc held low 3 cycles in S7:
  - S6: OP=4, mar_ld=1.
  - S7 held 4 cycles with mem_mov=1, mem_rw=1, ME=1, mdr_ld=1.
  - S8: MB=2, OP=13, rf_ld=1.
- BL, ir=32'hEB000002 → S12 with MC=2, OP=16, rf_ld=1; then S13 with MC=3, MB=1, OP=4; then S1.
- Condition fail and reset in S11:
  - ir=32'h00821003 with cond_true=0 → S4 goes directly to S1; rf_ld never asserted.
  - STR ir=32'hE5810000 with reset asserted while in S11 → mem_mov=0 and state=0 immediately.

Source files
------------

// File: rtl/arm_control_fsm_if.sv
// Control-unit interface: instruction/status inputs from the datapath and
// memory, and the mux selects, ALU op and load enables driven back to them.
interface arm_ctrl_if;
  logic [31:0] ir;
  logic        cond_true;
  logic        moc;
  logic [1:0]  MA;
  logic [1:0]  MB;
  logic [2:0]  MC;
  logic        MD;
  logic        ME;
  logic [1:0]  MJ;
  logic [4:0]  OP;
  logic        rf_ld;
  logic        ir_ld;
  logic        mar_ld;
  logic        mdr_ld;
  logic        flags_ld;
  logic        mem_mov;
  logic        mem_rw;
  logic [3:0]  state;

  modport master (
    input  ir, cond_true, moc,
    output MA, MB, MC, MD, ME, MJ, OP,
    output rf_ld, ir_ld, mar_ld, mdr_ld, flags_ld, mem_mov, mem_rw, state
  );

  modport slave (
    output ir, cond_true, moc,
    input  MA, MB, MC, MD, ME, MJ, OP,
    input  rf_ld, ir_ld, mar_ld, mdr_ld, flags_ld, mem_mov, mem_rw, state
  );
endinterface

// File: rtl/arm_control_fsm.sv
// Control FSM for the ARM-subset datapath: fetch / decode / execute for
// data-processing, LDR/STR and B/BL. Outputs are registered from the
// decode of the next state so they line up with the state register; only
// ir_ld is Mealy on moc so the IR captures memory data in the completing cycle.
module arm_control_fsm (
  input  logic       clk,
  input  logic       reset,
  arm_ctrl_if.master ctl
);

  typedef enum logic [3:0] {
    S0  = 4'd0,  S1  = 4'd1,  S2  = 4'd2,  S3  = 4'd3,
    S4  = 4'd4,  S5  = 4'd5,  S6  = 4'd6,  S7  = 4'd7,
    S8  = 4'd8,  S9  = 4'd9,  S10 = 4'd10, S11 = 4'd11,
    S12 = 4'd12, S13 = 4'd13
  } state_t;

  typedef struct packed {
    logic [1:0] ma;
    logic [1:0] mb;
    logic [2:0] mc;
    logic       md;
    logic       me;
    logic [1:0] mj;
    logic [4:0] op;
    logic       rf_ld;
    logic       mar_ld;
    logic       mdr_ld;
    logic       flags_ld;
    logic       mem_mov;
    logic       mem_rw;
  } ctl_t;

  state_t state_r;
  state_t next_s;
  ctl_t   out_r;
  ctl_t   next_out_s;

  // ir_hi carries ir[27:23]; ir_l is ir[20]. Unused encodings fall back to fetch.
  function automatic state_t next_state(input state_t st, input logic [4:0] ir_hi,
                                        input logic ir_l, input logic cond,
                                        input logic moc);
    state_t ns;
    ns = S1;
    case (st)
      S0:  ns = S1;
      S1:  ns = S2;
      S2:  ns = S3;
      S3:  ns = moc ? S4 : S3;
      S4: begin
        if (!cond) begin
          ns = S1;
        end else if (ir_hi[4:3] == 2'b00) begin
          ns = S5;
        end else if (ir_hi[4:2] == 3'b010) begin
          ns = ir_l ? S6 : S9;
        end else if (ir_hi[4:2] == 3'b101) begin
          ns = ir_hi[1] ? S12 : S13;
        end else begin
          ns = S1;
        end
      end
      S5:  ns = S1;
      S6:  ns = S7;
      S7:  ns = moc ? S8 : S7;
      S8:  ns = S1;
      S9:  ns = S10;
      S10: ns = S11;
      S11: ns = moc ? S1 : S11;
      S12: ns = S13;
      S13: ns = S1;
      default: ns = S1;
    endcase
    return ns;
  endfunction

  // pu carries ir[24:23]; s is ir[20] (set-flags bit for data-processing).
  function automatic ctl_t decode(input state_t st, input logic [1:0] pu, input logic s);
    ctl_t o;
    o = '0;
    case (st)
      S1: begin
        o.ma = 2'd2; o.md = 1'b1; o.op = 5'd16; o.mar_ld = 1'b1;
      end
      S2: begin
        o.ma = 2'd2; o.md = 1'b1; o.op = 5'd17; o.mc = 3'd3; o.rf_ld = 1'b1;
        o.mem_mov = 1'b1; o.mem_rw = 1'b1;
      end
      S3: begin
        o.mem_mov = 1'b1; o.mem_rw = 1'b1;
      end
      S5: begin
        // TST/TEQ/CMP/CMN (opcode 10xx) only update flags
        o.ma = 2'd0; o.mb = 2'd1; o.md = 1'b0; o.mc = 3'd0;
        o.rf_ld = (pu != 2'b10); o.flags_ld = s;
      end
      S6, S9: begin
        // U bit selects add or subtract of the immediate offset
        o.ma = 2'd0; o.mb = 2'd1; o.md = 1'b1; o.op = pu[0] ? 5'd4 : 5'd2;
        o.mar_ld = 1'b1;
      end
      S7: begin
        o.mem_mov = 1'b1; o.mem_rw = 1'b1; o.me = 1'b1; o.mdr_ld = 1'b1;
      end
      S8: begin
        o.mb = 2'd2; o.md = 1'b1; o.op = 5'd13; o.mc = 3'd0; o.rf_ld = 1'b1;
      end
      S10: begin
        o.mj = 2'd2; o.mb = 2'd0; o.md = 1'b1; o.op = 5'd13; o.me = 1'b0;
        o.mdr_ld = 1'b1;
      end
      S11: begin
        o.mem_mov = 1'b1; o.mem_rw = 1'b0;
      end
      S12: begin
        o.ma = 2'd2; o.md = 1'b1; o.op = 5'd16; o.mc = 3'd2; o.rf_ld = 1'b1;
      end
      S13: begin
        o.ma = 2'd2; o.mb = 2'd1; o.md = 1'b1; o.op = 5'd4; o.mc = 3'd3;
        o.rf_ld = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  assign next_s     = next_state(state_r, ctl.ir[27:23], ctl.ir[20], ctl.cond_true, ctl.moc);
  assign next_out_s = decode(next_s, ctl.ir[24:23], ctl.ir[20]);

  // State register plus output registers preloaded with the next state's decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S0;
      out_r   <= '0;
    end else begin
      state_r <= next_s;
      out_r   <= next_out_s;
    end
  end

  assign ctl.MA       = out_r.ma;
  assign ctl.MB       = out_r.mb;
  assign ctl.MC       = out_r.mc;
  assign ctl.MD       = out_r.md;
  assign ctl.ME       = out_r.me;
  assign ctl.MJ       = out_r.mj;
  assign ctl.OP       = out_r.op;
  assign ctl.rf_ld    = out_r.rf_ld;
  assign ctl.mar_ld   = out_r.mar_ld;
  assign ctl.mdr_ld   = out_r.mdr_ld;
  assign ctl.flags_ld = out_r.flags_ld;
  assign ctl.mem_mov  = out_r.mem_mov;
  assign ctl.mem_rw   = out_r.mem_rw;
  assign ctl.state    = state_r;
  assign ctl.ir_ld    = (state_r == S3) && ctl.moc;

endmodule
